// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: default register address,
// FSM encoding and frame length. Define UART_TX_PARITY_EN for 8E1 frames; default is 8N1.
package mmio_pkg;

  localparam logic [7:0] TX_ADDR_DEFAULT = 8'hFF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
`ifdef UART_TX_PARITY_EN
    PARITY = S_PARITY,
`endif
    STOP   = S_STOP
  } uart_state_e;

  localparam int DATA_BITS  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Store-side bus from the MEM stage into the UART transmitter.
interface mmio_uart_tx_if;
  logic        wren;
  logic [7:0]  addr;
  logic [31:0] din;

  modport master (output wren, addr, din);
  modport slave  (input  wren, addr, din);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO between the store port and the transmit FSM; a push is accepted when full
// only if a pop happens in the same cycle.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // NOTE: storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue a byte, the FSM serialises it.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  TX_ADDR      = TX_ADDR_DEFAULT
) (
  input  logic                 clock,
  input  logic                 clear,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e r_state, w_state_next;
  logic [15:0] r_baud, w_baud_next;
  logic [2:0]  r_bit, w_bit_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_tx, w_tx_next;
  logic        r_overflow;

  logic        w_hit;
  logic        w_push;
  logic        w_pop;
  logic        w_baud_done;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic        w_unused_bits;

  assign w_hit         = bus.wren && (bus.addr == TX_ADDR);
  assign w_push        = w_hit && !clear;
  assign w_baud_done   = (r_baud == BAUD_LAST);
  assign w_unused_bits = ^{bus.din[31:8], w_fifo_count};

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.din[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // see pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // tx is driven from next-state logic into r_tx, so the line changes on the same
  // edge as the state and never sees a combinational path from the inputs.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_dout;
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = START;
          w_tx_next    = 1'b0;
        end
      end

      START: begin
        w_tx_next = 1'b0;
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      DATA: begin
        w_tx_next = r_shift[r_bit];
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit == BIT_LAST) begin
            w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
            w_tx_next    = even_parity(r_shift);
`else
            w_state_next = STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_shift[r_bit + 3'd1];
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx_next = even_parity(r_shift);
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
`endif

      STOP: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = IDLE;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      default: begin
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // A write into a full FIFO is lost unless the FSM frees a slot on the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_hit && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE) || !w_fifo_empty;
  assign full     = w_fifo_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; a line monitor
// decodes frames and compares them against bytes queued by the writers.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic clock;
  logic clear;
  logic tx, busy, full, overflow;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (8'hFF)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .bus      (bus),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int frames_rx = 0;
  logic [7:0] sb [$];
  logic mon_abort;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input bit accepted);
    bus.wren = 1'b1;
    bus.addr = a;
    bus.din  = d;
    if (accepted) sb.push_back(d[7:0]);
    tick(1);
    bus.wren = 1'b0;
    bus.addr = 8'h00;
    bus.din  = 32'h0;
  endtask

  task automatic wait_not_busy(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {31'b0, tx}, 32'd0);
  endtask

  task automatic watch_quiet(input int n, output logic low_seen, output logic busy_seen,
                             output logic cnt_seen);
    low_seen = 1'b0; busy_seen = 1'b0; cnt_seen = 1'b0;
    repeat (n) begin
      tick(1);
      if (tx !== 1'b1)             low_seen  = 1'b1;
      if (busy !== 1'b0)           busy_seen = 1'b1;
      if (dut.u_fifo.count !== '0) cnt_seen  = 1'b1;
    end
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clock);
      if (clear) mon_abort = 1'b1;
    end
  endtask

  // Line monitor: samples each bit near its middle on falling clock edges.
  initial begin : monitor
    logic       prev_tx;
    logic [7:0] got;
    logic [7:0] exp;
    logic       start_b, stop_b, par_b;
    int         last_start;
    prev_tx    = 1'b1;
    last_start = -1000;
    par_b      = 1'b0;
    forever begin
      @(negedge clock);
      if (!clear && prev_tx === 1'b1 && tx === 1'b0) begin
        mon_abort = 1'b0;
        if (cyc - last_start < FRAME_CYC + 4)
          check("b2b_gap", cyc - last_start, FRAME_CYC + 1);
        last_start = cyc;
        mon_wait(CPB / 2);
        start_b = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        mon_wait(CPB);
        par_b = tx;
`endif
        mon_wait(CPB);
        stop_b = tx;
        if (mon_abort) begin
          last_start = -1000;
        end else if (sb.size() == 0) begin
          check("frame_unexpected", {24'h0, got}, 32'hFFFF_FFFF);
        end else begin
          exp = sb.pop_front();
          check("frame_data", {24'h0, got}, {24'h0, exp});
          check("start_bit", {31'b0, start_b}, 32'd0);
          check("stop_bit", {31'b0, stop_b}, 32'd1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'b0, par_b}, {31'b0, ^exp});
`endif
          frames_rx++;
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic low_seen, busy_seen, cnt_seen;
    int   t0, f0;

    clear    = 1'b1;
    bus.wren = 1'b0;
    bus.addr = 8'h00;
    bus.din  = 32'h0;
    tick(3);

    // A store coinciding with clear must be lost.
    do_write(8'hFF, 32'h99, 1'b0);
    clear = 1'b0;
    tick(1);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_count", 32'(dut.u_fifo.count), 32'd0);
    watch_quiet(50, low_seen, busy_seen, cnt_seen);
    check("clear_write_dropped", {31'b0, low_seen}, 32'd0);

    // Store to a neighbouring address is ignored.
    do_write(8'hFE, 32'h55, 1'b0);
    watch_quiet(60, low_seen, busy_seen, cnt_seen);
    check("badaddr_tx_quiet", {31'b0, low_seen}, 32'd0);
    check("badaddr_busy_low", {31'b0, busy_seen}, 32'd0);
    check("badaddr_count_zero", {31'b0, cnt_seen}, 32'd0);

    // Single byte; upper store-data bits must be ignored.
    do_write(8'hFF, 32'hDEAD_BE41, 1'b1);
    check("busy_after_push", {31'b0, busy}, 32'd1);
    wait_tx_low(4, "tx_low_within_4");
    t0 = cyc;
    wait_not_busy(200, "single_busy_fall");
    check("single_frame_len", cyc - t0, FRAME_CYC);

    // Six stores back to back into a 4-deep FIFO: one pops at once, the sixth is lost.
    tick(5);
    f0 = frames_rx;
    do_write(8'hFF, 32'h11, 1'b1);
    do_write(8'hFF, 32'h22, 1'b1);
    do_write(8'hFF, 32'h33, 1'b1);
    do_write(8'hFF, 32'h44, 1'b1);
    do_write(8'hFF, 32'h5A, 1'b1);
    do_write(8'hFF, 32'h66, 1'b0);
    check("burst_overflow", {31'b0, overflow}, 32'd1);
    check("burst_full", {31'b0, full}, 32'd1);
    wait_not_busy(6 * (FRAME_CYC + 1) + 20, "burst_drain");
    check("burst_frames", frames_rx - f0, 32'd5);
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    check("burst_sb_empty", sb.size(), 32'd0);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_overflow", {31'b0, overflow}, 32'd0);

    // Fill to full, then store on the one idle cycle after the first frame's stop bit:
    // the pop frees a slot on that edge so the push must be kept without overflow.
    tick(2);
    f0 = frames_rx;
    do_write(8'hFF, 32'hC1, 1'b1);
    do_write(8'hFF, 32'hC2, 1'b1);
    do_write(8'hFF, 32'hC3, 1'b1);
    do_write(8'hFF, 32'hC4, 1'b1);
    do_write(8'hFF, 32'hC5, 1'b1);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_no_overflow", {31'b0, overflow}, 32'd0);
    // First push edge E0, frame starts E0+1, STOP ends E0+1+FRAME_CYC, pop on the next edge.
    tick(FRAME_CYC + 1 - 4);
    do_write(8'hFF, 32'hC6, 1'b1);
    check("pushpop_no_overflow", {31'b0, overflow}, 32'd0);
    check("pushpop_full", {31'b0, full}, 32'd1);
    check("pushpop_count", 32'(dut.u_fifo.count), DEPTH);
    wait_not_busy(7 * (FRAME_CYC + 1) + 20, "pushpop_drain");
    check("pushpop_frames", frames_rx - f0, 32'd6);

    // Clear in the middle of a frame aborts it.
    tick(3);
    do_write(8'hFF, 32'hA5, 1'b0);
    wait_tx_low(8, "abort_frame_start");
    tick(9);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("abort_tx_high", {31'b0, tx}, 32'd1);
    check("abort_state_idle", 32'(dut.r_state), 32'(mmio_pkg::S_IDLE));
    check("abort_count", 32'(dut.u_fifo.count), 32'd0);
    check("abort_overflow", {31'b0, overflow}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    watch_quiet(3 * FRAME_CYC, low_seen, busy_seen, cnt_seen);
    check("abort_line_quiet", {31'b0, low_seen}, 32'd0);

`ifdef UART_TX_PARITY_EN
    do_write(8'hFF, 32'h07, 1'b1);
    wait_tx_low(4, "par07_start");
    t0 = cyc;
    wait_not_busy(200, "par07_busy_fall");
    check("par07_frame_len", cyc - t0, 32'd44);
    tick(3);
    do_write(8'hFF, 32'h03, 1'b1);
    wait_not_busy(200, "par03_busy_fall");
`endif

    tick(CPB * 2);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte entries, power of two, 2..64.
REQ-003 SHALL have parameter TX_ADDR, default 8'hFF, data-memory byte address decoded as the transmit register.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports are clock (1-bit input) and clear (1-bit input).
REQ-005 SHALL have port wren, input, 1 bit: store strobe from the MEM stage.
REQ-006 SHALL have port addr, input, 8 bits: store address, equal to MEM ALU result bits [7:0].
REQ-007 SHALL have port din, input, 32 bits: store data; only bits [7:0] are used.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-012 A push SHALL occur on a rising clock when wren=1 and addr==TX_ADDR; din[7:0] is enqueued and is visible to the FSM on the next cycle.
REQ-013 When a write arrives with full=1 and no pop occurs in the same cycle, the byte SHALL be dropped and overflow set to 1; overflow stays at 1 until clear.
REQ-014 When a push and a pop occur in the same cycle with the FIFO full, the push SHALL be accepted, the count SHALL stay at FIFO_DEPTH, and overflow SHALL NOT be set.
REQ-015 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-017 IDLE: tx=1. When the FIFO is non-empty, the FSM SHALL pop the head into the shift register and enter START on the next clock.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA SHALL drive 8 bits, LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index counter.
REQ-020 After DATA the FSM SHALL enter PARITY if the macro is defined, else STOP.
REQ-021 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-022 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-023 Back-to-back frames SHALL have exactly one IDLE cycle between the end of STOP and the next START.
REQ-024 tx SHALL be registered, with no combinational path from any input to tx.
REQ-025 Writes to any address other than TX_ADDR SHALL be ignored.

Reset
REQ-026 When clear=1 at a rising clock, the block SHALL set state=IDLE, tx=1, busy=0, full=0, overflow=0, FIFO count and pointers to 0, and the bit and baud counters to 0.
REQ-027 A clear asserted mid-frame SHALL abort the frame and drive tx=1 from the next cycle.
REQ-028 A write in the same cycle as clear SHALL be discarded.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) after bit 7, lasting CLKS_PER_BIT cycles.
REQ-030 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent; frame format is 8N1.

Structure
REQ-031 Shared package mmio_pkg SHALL hold the default TX_ADDR constant, the FSM state encoding (3-bit localparams) and the frame-length constants.
REQ-032 The FIFO SHALL be a sub-module named tx_fifo (push, pop, din, dout, full, empty, count).
REQ-033 The FSM, baud counter and overflow flag SHALL live in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 8'h41 to addr 8'hFF -> tx low 4 cycles later, line reads 0,1,0,0,0,0,0,1,0,1 (start, LSB first, stop), 4 cycles per bit; busy falls after 40+ cycles.
REQ-035 Write 6 bytes in 6 consecutive cycles -> first 5 accepted (one pops immediately), 6th dropped, overflow=1, exactly 5 frames transmitted in order.
REQ-036 Write 8'h55 to addr 8'hFE -> tx stays 1, busy stays 0, FIFO count stays 0.
REQ-037 Assert clear at cycle 10 of a frame for 8'hA5 -> tx=1 the next cycle, state IDLE, FIFO empty, overflow=0, no further edges on tx.
REQ-038 With UART_TX_PARITY_EN defined, write 8'h07 -> parity bit=1 and frame length 44 cycles; write 8'h03 -> parity bit=0.
